// File: rtl/reaction_score_keeper.sv
// Reaction-timer score keeper: validates BCD results, keeps the best (lowest) time,
// counts accepted attempts and selects what the seven-segment display shows.
module reaction_score_keeper (
    input  logic        MAX10_CLK1_50,
    input  logic        reset_n,
    input  logic        result_valid,
    input  logic [15:0] result_bcd,
    input  logic        clear_hs,
    input  logic        show_hs,
    output logic [15:0] disp_bcd,
    output logic        hs_valid,
    output logic [7:0]  attempts,
    output logic        busy,
    output logic        done,
    output logic        new_record,
    output logic        bad_result
);

    // state | meaning
    // IDLE  | waiting for result_valid (only state that samples it)
    // CMP   | digit-serial compare of last vs high score, thousands first
    // UPD   | replace high score if needed, bump attempts, queue done
    typedef enum logic [1:0] {IDLE, CMP, UPD} state_t;
    typedef enum logic [1:0] {CMP_EQ, CMP_LT, CMP_GT} cmp_t;

    state_t      state;
    cmp_t        cmp_res;
    logic [1:0]  idx;
    logic [15:0] last_q;
    logic [15:0] hs_q;
    logic        done_pend;
    logic        rec_pend;
    logic        result_ok;
    logic [3:0]  last_dig;
    logic [3:0]  hs_dig;
    logic [7:0]  attempts_inc;

    always_comb begin
        result_ok = 1'b1;
        for (int d = 0; d < 4; d++) begin
            if (result_bcd[d*4 +: 4] > 4'd9) result_ok = 1'b0;
        end
    end

    assign last_dig = last_q[{idx, 2'b00} +: 4];
    assign hs_dig   = hs_q[{idx, 2'b00} +: 4];

    // BCD increment that sticks at 99
    always_comb begin
        attempts_inc = attempts;
        if (attempts != 8'h99) begin
            if (attempts[3:0] == 4'd9) attempts_inc = {attempts[7:4] + 4'd1, 4'd0};
            else                       attempts_inc = {attempts[7:4], attempts[3:0] + 4'd1};
        end
    end

    assign disp_bcd = show_hs ? (hs_valid ? hs_q : 16'h9999) : last_q;

    always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cmp_res    <= CMP_EQ;
            idx        <= 2'd0;
            last_q     <= 16'h0000;
            hs_q       <= 16'h9999;
            hs_valid   <= 1'b0;
            attempts   <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
            new_record <= 1'b0;
            bad_result <= 1'b0;
            done_pend  <= 1'b0;
            rec_pend   <= 1'b0;
        end else begin
            done       <= 1'b0;
            new_record <= 1'b0;
            bad_result <= 1'b0;
            if (clear_hs) begin
                state     <= IDLE;
                hs_q      <= 16'h9999;
                hs_valid  <= 1'b0;
                attempts  <= 8'h00;
                busy      <= 1'b0;
                done_pend <= 1'b0;
                rec_pend  <= 1'b0;
            end else begin
                // busy stays up through the pending cycle so IDLE cannot re-sample early
                if (done_pend) begin
                    done       <= 1'b1;
                    new_record <= rec_pend;
                    busy       <= 1'b0;
                    done_pend  <= 1'b0;
                    rec_pend   <= 1'b0;
                end
                case (state)
                    IDLE: begin
                        if (result_valid && !busy) begin
                            if (result_ok) begin
                                last_q  <= result_bcd;
                                idx     <= 2'd3;
                                cmp_res <= CMP_EQ;
                                busy    <= 1'b1;
                                state   <= CMP;
                            end else begin
                                bad_result <= 1'b1;
                            end
                        end
                    end
                    CMP: begin
                        if (cmp_res == CMP_EQ && last_dig != hs_dig)
                            cmp_res <= (last_dig < hs_dig) ? CMP_LT : CMP_GT;
                        if (idx == 2'd0) state <= UPD;
                        else             idx   <= idx - 2'd1;
                    end
                    UPD: begin
                        if (!hs_valid || cmp_res == CMP_LT) begin
                            hs_q     <= last_q;
                            hs_valid <= 1'b1;
                            rec_pend <= 1'b1;
                        end
                        attempts  <= attempts_inc;
                        done_pend <= 1'b1;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reaction_score_keeper.sv
// Directed bench for reaction_score_keeper with hand-computed expectations.
module tb_reaction_score_keeper;

    logic        clk;
    logic        reset_n;
    logic        result_valid;
    logic [15:0] result_bcd;
    logic        clear_hs;
    logic        show_hs;
    logic [15:0] disp_bcd;
    logic        hs_valid;
    logic [7:0]  attempts;
    logic        busy;
    logic        done;
    logic        new_record;
    logic        bad_result;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int d0;

    reaction_score_keeper dut (
        .MAX10_CLK1_50 (clk),
        .reset_n       (reset_n),
        .result_valid  (result_valid),
        .result_bcd    (result_bcd),
        .clear_hs      (clear_hs),
        .show_hs       (show_hs),
        .disp_bcd      (disp_bcd),
        .hs_valid      (hs_valid),
        .attempts      (attempts),
        .busy          (busy),
        .done          (done),
        .new_record    (new_record),
        .bad_result    (bad_result)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Leaves the bench at the negedge right after the sampling edge.
    task automatic send(input logic [15:0] v);
        @(negedge clk);
        result_valid = 1'b1;
        result_bcd   = v;
        @(negedge clk);
        result_valid = 1'b0;
    endtask

    task automatic send_timed(input string tag, input logic [15:0] v, input logic exp_rec);
        send(v);
        repeat (5) @(negedge clk);
        check({tag, " done_early"}, {31'd0, done}, 32'd0);
        check({tag, " busy_before"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " new_record"}, {31'd0, new_record}, {31'd0, exp_rec});
        check({tag, " busy_after"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        check({tag, " done_width"}, {31'd0, done | new_record}, 32'd0);
    endtask

    task automatic show(input string tag, input logic sel, input logic [15:0] exp);
        show_hs = sel;
        #1;
        check(tag, {16'd0, disp_bcd}, {16'd0, exp});
    endtask

    initial begin
        reset_n      = 1'b0;
        result_valid = 1'b0;
        result_bcd   = 16'h0000;
        clear_hs     = 1'b0;
        show_hs      = 1'b1;
        #25;
        check("rst disp", {16'd0, disp_bcd}, 32'h9999);
        check("rst hs_valid", {31'd0, hs_valid}, 32'd0);
        check("rst attempts", {24'd0, attempts}, 32'h00);
        check("rst busy", {31'd0, busy}, 32'd0);
        show("rst last", 1'b0, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;

        send_timed("r0312a", 16'h0312, 1'b1);
        show("hs 0312", 1'b1, 16'h0312);
        check("hs_valid 1", {31'd0, hs_valid}, 32'd1);
        check("att 01", {24'd0, attempts}, 32'h01);
        send_timed("r0312b", 16'h0312, 1'b0);
        check("att 02", {24'd0, attempts}, 32'h02);

        send_timed("r0299", 16'h0299, 1'b1);
        show("hs 0299", 1'b1, 16'h0299);
        send_timed("r1000", 16'h1000, 1'b0);
        show("last 1000", 1'b0, 16'h1000);
        show("hs still 0299", 1'b1, 16'h0299);
        check("att 04", {24'd0, attempts}, 32'h04);

        d0 = done_cnt;
        send(16'h03A2);
        check("bad pulse", {31'd0, bad_result}, 32'd1);
        check("bad not busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("bad width", {31'd0, bad_result}, 32'd0);
        repeat (7) @(negedge clk);
        check("bad no done", done_cnt, d0);
        check("bad att", {24'd0, attempts}, 32'h04);
        show("bad last kept", 1'b0, 16'h1000);

        d0 = done_cnt;
        send(16'h0500);
        @(negedge clk);
        result_valid = 1'b1;
        result_bcd   = 16'h0001;
        @(negedge clk);
        result_bcd   = 16'h00F0;
        @(negedge clk);
        result_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("busy ign dones", done_cnt, d0 + 1);
        check("busy ign att", {24'd0, attempts}, 32'h05);
        check("busy ign bad", {31'd0, bad_result}, 32'd0);
        show("busy ign last", 1'b0, 16'h0500);
        show("busy ign hs", 1'b1, 16'h0299);

        d0 = done_cnt;
        send(16'h0100);
        @(negedge clk);
        clear_hs = 1'b1;
        @(negedge clk);
        clear_hs = 1'b0;
        check("clr busy", {31'd0, busy}, 32'd0);
        repeat (8) @(negedge clk);
        check("clr no done", done_cnt, d0);
        check("clr hs_valid", {31'd0, hs_valid}, 32'd0);
        check("clr att", {24'd0, attempts}, 32'h00);
        show("clr hs", 1'b1, 16'h9999);
        show("clr last kept", 1'b0, 16'h0100);

        d0 = done_cnt;
        @(negedge clk);
        clear_hs     = 1'b1;
        result_valid = 1'b1;
        result_bcd   = 16'h0050;
        @(negedge clk);
        clear_hs     = 1'b0;
        result_valid = 1'b0;
        check("clr+rv busy", {31'd0, busy}, 32'd0);
        repeat (8) @(negedge clk);
        check("clr+rv no done", done_cnt, d0);
        show("clr+rv last", 1'b0, 16'h0100);

        for (int i = 1; i <= 100; i++) begin
            send(16'h0123);
            repeat (7) @(negedge clk);
            if (i == 9)   check("att 09", {24'd0, attempts}, 32'h09);
            if (i == 10)  check("att 10", {24'd0, attempts}, 32'h10);
            if (i == 99)  check("att 99", {24'd0, attempts}, 32'h99);
            if (i == 100) check("att sat", {24'd0, attempts}, 32'h99);
        end
        show("loop hs", 1'b1, 16'h0123);

        d0 = done_cnt;
        send(16'h0077);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst mid busy", {31'd0, busy}, 32'd0);
        check("rst mid att", {24'd0, attempts}, 32'h00);
        check("rst mid hs_valid", {31'd0, hs_valid}, 32'd0);
        show("rst mid last", 1'b0, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        check("rst mid no done", done_cnt, d0);
        check("rst mid no rec", {31'd0, new_record}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
